// File: rtl/adder_meas_pkg.sv
// adder_meas_pkg: shared types and constants for the adder measurement sequencer.
//   meas_state_e  : sequencer FSM states
//   RING_IN_BIT   : a-operand bit the ring oscillator is injected into
//   REF_INDEX     : result_bit value reported for the bypass reference run
//   meas_result_t : one measurement record (bit index, ring count, timeout)
package adder_meas_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LOAD,
        RUN,
        CAPTURE,
        RESULT,
        FINISH
    } meas_state_e;

    localparam int         RING_IN_BIT = 0;
    localparam logic [3:0] REF_INDEX   = 4'd8;

    typedef struct packed {
        logic [3:0]  bit_idx;
        logic [31:0] count;
        logic        timeout;
    } meas_result_t;

endpackage

// File: rtl/adder_meas_watchdog.sv
// adder_meas_watchdog: 33-bit RUN-phase cycle counter.
//   clk, reset_b : clock, synchronous active-low reset
//   clear        : zero the counter
//   enable       : count this cycle
//   limit        : cycle budget (integration time + margin)
//   expired      : high during the enabled cycle that uses up the budget,
//                  so a limit of N ends the phase after exactly N cycles
module adder_meas_watchdog (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        clear,
    input  logic        enable,
    input  logic [32:0] limit,
    output logic        expired
);

    logic [32:0] count;
    logic [32:0] count_next;

    assign count_next = count + 33'd1;

    always_ff @(posedge clk) begin
        if (!reset_b)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable)
            count <= count_next;
    end

    // count_next is the number of cycles elapsed including this one;
    // >= keeps a zero budget from slipping past the compare.
    assign expired = enable && (count_next >= limit);

endmodule

// File: rtl/adder_measure_sequencer.sv
// adder_measure_sequencer: drives the instrumented adder's ring/counter
// controls through one timed measurement per selected sum bit and streams
// the results out over valid/ready.
//   wb_clk_i, reset_b          : clock, synchronous active-low reset
//   start, bit_mask, integ_time_i, a_val_i, b_val_i : sweep launch (IDLE only)
//   busy, sweep_done           : sweep status, done is a one-cycle pulse
//   result_*                   : measurement stream (bit, count, timeout)
//   adder_reset..b_input       : controls to the adder
//   done, ring_count_i         : status from the adder
// Build option: ADDER_MEAS_BYPASS_REF_EN adds a bypassed reference run
// (result_bit 8) at the head of every non-empty sweep.
module adder_measure_sequencer
    import adder_meas_pkg::*;
#(
    parameter int NUM_BITS       = 8,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_MARGIN = 16
) (
    input  logic                wb_clk_i,
    input  logic                reset_b,
    input  logic                start,
    input  logic [NUM_BITS-1:0] bit_mask,
    input  logic [31:0]         integ_time_i,
    input  logic [NUM_BITS-1:0] a_val_i,
    input  logic [NUM_BITS-1:0] b_val_i,
    output logic                busy,
    output logic                sweep_done,
    output logic                result_valid,
    input  logic                result_ready,
    output logic [3:0]          result_bit,
    output logic [31:0]         result_count,
    output logic                result_timeout,
    output logic                adder_reset,
    output logic                stop_b,
    output logic                bypass_b,
    output logic                control_b,
    output logic                extra_inverter,
    output logic [NUM_BITS-1:0] a_input_ext_bit_b,
    output logic [NUM_BITS-1:0] a_input_ring_bit_b,
    output logic [NUM_BITS-1:0] s_output_bit_b,
    output logic                counter_enable,
    output logic                counter_load,
    output logic [31:0]         integration_time,
    output logic [NUM_BITS-1:0] a_input,
    output logic [NUM_BITS-1:0] b_input,
    input  logic                done,
    input  logic [31:0]         ring_count_i
);

`ifdef ADDER_MEAS_BYPASS_REF_EN
    localparam bit REF_EN = 1'b1;
`else
    localparam bit REF_EN = 1'b0;
`endif

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    meas_state_e         state, state_next;
    logic [SW-1:0]       settle_cnt;
    logic [NUM_BITS-1:0] pend_mask;
    logic [3:0]          cur_bit;
    logic                is_ref;
    logic                timeout_q;
    meas_result_t        res;

    logic [NUM_BITS-1:0] search_src;
    logic [3:0]          found_idx;
    logic                settle_done;
    logic                active;
    logic                wd_expired;

    adder_meas_watchdog u_watchdog (
        .clk     (wb_clk_i),
        .reset_b (reset_b),
        .clear   (state == LOAD),
        .enable  (state == RUN),
        .limit   ({1'b0, integration_time} + 33'(TIMEOUT_MARGIN)),
        .expired (wd_expired)
    );

    // Lowest set bit: search the fresh mask at launch, the remainder later.
    always_comb begin
        search_src = (state == IDLE) ? bit_mask : pend_mask;
        found_idx  = '0;
        for (int i = NUM_BITS - 1; i >= 0; i--)
            if (search_src[i]) found_idx = 4'(i);
    end

    assign settle_done = (settle_cnt == SW'(SETTLE_CYCLES - 1));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (bit_mask == '0) ? FINISH : SETUP;
            SETUP:   if (settle_done) state_next = LOAD;
            LOAD:    state_next = RUN;
            RUN:     if (done || wd_expired) state_next = CAPTURE;
            CAPTURE: state_next = RESULT;
            RESULT:  if (result_ready) state_next = (pend_mask != '0) ? SETUP : FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!reset_b) begin
            state            <= IDLE;
            settle_cnt       <= '0;
            pend_mask        <= '0;
            cur_bit          <= '0;
            is_ref           <= 1'b0;
            timeout_q        <= 1'b0;
            res              <= '0;
            sweep_done       <= 1'b0;
            integration_time <= '0;
            a_input          <= '0;
            b_input          <= '0;
        end else begin
            state      <= state_next;
            sweep_done <= (state == FINISH);
            settle_cnt <= (state == SETUP) ? settle_cnt + SW'(1) : '0;
            case (state)
                IDLE: if (start) begin
                    integration_time <= integ_time_i;
                    a_input          <= a_val_i;
                    b_input          <= b_val_i;
                    if (REF_EN) begin
                        // Reference run first; the whole mask stays pending.
                        is_ref    <= 1'b1;
                        cur_bit   <= REF_INDEX;
                        pend_mask <= bit_mask;
                    end else begin
                        is_ref    <= 1'b0;
                        cur_bit   <= found_idx;
                        pend_mask <= bit_mask & ~(NUM_BITS'(1) << found_idx);
                    end
                end
                // done has priority over a same-cycle watchdog expiry.
                RUN: if (done || wd_expired) timeout_q <= !done;
                CAPTURE: begin
                    res.bit_idx <= cur_bit;
                    res.count   <= ring_count_i;
                    res.timeout <= timeout_q;
                end
                RESULT: if (result_ready && pend_mask != '0) begin
                    is_ref    <= 1'b0;
                    cur_bit   <= found_idx;
                    pend_mask <= pend_mask & ~(NUM_BITS'(1) << found_idx);
                end
                default: ;
            endcase
        end
    end

    assign active = state inside {SETUP, LOAD, RUN, CAPTURE, RESULT};

    assign busy           = (state != IDLE);
    assign result_valid   = (state == RESULT);
    assign result_bit     = res.bit_idx;
    assign result_count   = res.count;
    assign result_timeout = res.timeout;

    // Adder is held in reset except while the counter is loaded, runs and is read.
    assign adder_reset    = !(state inside {LOAD, RUN, CAPTURE});
    assign stop_b         = state inside {IDLE, RUN, FINISH};
    assign counter_enable = (state == RUN);
    assign counter_load   = (state == LOAD);
    assign control_b      = 1'b1;
    assign extra_inverter = 1'b0;

`ifdef ADDER_MEAS_BYPASS_REF_EN
    assign bypass_b = !(is_ref && active);
`else
    assign bypass_b = 1'b1;
`endif

    assign a_input_ext_bit_b  = '1;
    assign a_input_ring_bit_b = active ? ~(NUM_BITS'(1) << RING_IN_BIT) : '1;
    // The reference run taps the ring at sum bit 0.
    assign s_output_bit_b     = !active ? '1 :
                                is_ref  ? ~NUM_BITS'(1) :
                                          ~(NUM_BITS'(1) << cur_bit);

endmodule

// File: tb/tb_adder_measure_sequencer.sv
module tb_adder_measure_sequencer;

    logic        clk = 1'b0;
    logic        reset_b, start, result_ready, done;
    logic [7:0]  bit_mask, a_val, b_val;
    logic [31:0] integ, ring_count;
    logic        busy, sweep_done, result_valid, result_timeout;
    logic [3:0]  result_bit;
    logic [31:0] result_count, integration_time;
    logic        adder_reset, stop_b, bypass_b, control_b, extra_inverter;
    logic        counter_enable, counter_load;
    logic [7:0]  a_ext_b, a_ring_b, s_out_b, a_input, b_input;

    int n_pass = 0;
    int n_chk  = 0;

    // Adder stub: done fires on the done_at-th RUN cycle (0 = never).
    int          run_cnt  = 0;
    int          last_run = 0;
    int          done_at  = 0;
    logic [7:0]  run_sel  = '0;
    logic        run_byp  = 1'b0;

    always #5 clk = ~clk;

    assign done = (done_at != 0) && counter_enable && (run_cnt + 1 == done_at);

    always @(posedge clk) begin
        if (counter_enable) begin
            run_cnt <= run_cnt + 1;
            run_sel <= s_out_b;
            run_byp <= bypass_b;
        end else begin
            if (run_cnt != 0) last_run <= run_cnt;
            run_cnt <= 0;
        end
    end

    adder_measure_sequencer dut (
        .wb_clk_i           (clk),
        .reset_b            (reset_b),
        .start              (start),
        .bit_mask           (bit_mask),
        .integ_time_i       (integ),
        .a_val_i            (a_val),
        .b_val_i            (b_val),
        .busy               (busy),
        .sweep_done         (sweep_done),
        .result_valid       (result_valid),
        .result_ready       (result_ready),
        .result_bit         (result_bit),
        .result_count       (result_count),
        .result_timeout     (result_timeout),
        .adder_reset        (adder_reset),
        .stop_b             (stop_b),
        .bypass_b           (bypass_b),
        .control_b          (control_b),
        .extra_inverter     (extra_inverter),
        .a_input_ext_bit_b  (a_ext_b),
        .a_input_ring_bit_b (a_ring_b),
        .s_output_bit_b     (s_out_b),
        .counter_enable     (counter_enable),
        .counter_load       (counter_load),
        .integration_time   (integration_time),
        .a_input            (a_input),
        .b_input            (b_input),
        .done               (done),
        .ring_count_i       (ring_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic launch(input logic [7:0] m, input logic [31:0] t);
        bit_mask = m;
        integ    = t;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts edges until result_valid is seen on a falling edge.
    task automatic wait_valid(input int budget, output int cycles);
        cycles = 0;
        do begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end while (!result_valid && cycles < budget);
    endtask

    task automatic finish_sweep(output int pulses, output logic vseen);
        pulses = 0;
        vseen  = 1'b0;
        repeat (6) begin
            @(posedge clk);
            @(negedge clk);
            pulses += int'(sweep_done);
            vseen  |= result_valid;
        end
    endtask

    int   cyc, pulses;
    logic vseen;

    initial begin
        reset_b = 0; start = 0; result_ready = 0;
        bit_mask = '0; a_val = '0; b_val = '0; integ = '0; ring_count = '0;
        repeat (3) @(negedge clk);

        // Reset state: {adder_reset,stop_b,bypass_b,control_b,extra_inv,cen,cload,busy,sdone,valid,tout}
        check("rst_ctl", 64'({adder_reset, stop_b, bypass_b, control_b, extra_inverter,
                              counter_enable, counter_load, busy, sweep_done, result_valid,
                              result_timeout}), 64'(11'b11110000000));
        check("rst_sel", 64'({a_ext_b, a_ring_b, s_out_b}), 64'(24'hFFFFFF));
        check("rst_data", 64'({integration_time, a_input, b_input, result_bit}), 64'(0));
        check("rst_count", 64'(result_count), 64'(0));

        reset_b = 1;
        @(negedge clk);

        // Two-bit sweep, done after 100 RUN cycles, ready always high.
        a_val = 8'h3C; b_val = 8'hA5; ring_count = 32'd1234; done_at = 100; result_ready = 1;
        launch(8'h05, 32'd100);
        @(negedge clk);
        check("t1_busy", 64'(busy), 64'(1));
        wait_valid(300, cyc);
        // edges from the start cycle to the first valid cycle, counting the first busy edge
        check("t1_latency", 64'(cyc + 1), 64'(1 + 4 + 1 + 100 + 1));
        check("t1_valid0", 64'(result_valid), 64'(1));
        check("t1_res0", 64'({result_bit, result_count, result_timeout}), 64'({4'd0, 32'd1234, 1'b0}));
        check("t1_sel0", 64'(run_sel), 64'(8'hFE));
        check("t1_ring", 64'({a_ring_b, a_ext_b}), 64'(16'hFEFF));
        check("t1_ops", 64'({integration_time, a_input, b_input}), 64'({32'd100, 8'h3C, 8'hA5}));
        check("t1_run0", 64'(last_run), 64'(100));
        wait_valid(300, cyc);
        check("t1_valid1", 64'(result_valid), 64'(1));
        check("t1_res1", 64'({result_bit, result_count, result_timeout}), 64'({4'd2, 32'd1234, 1'b0}));
        check("t1_sel1", 64'(run_sel), 64'(8'hFB));
        check("t1_byp", 64'(run_byp), 64'(1));
        finish_sweep(pulses, vseen);
        check("t1_done_pulses", 64'(pulses), 64'(1));
        check("t1_tail", 64'({vseen, busy}), 64'(2'b00));

        // Empty mask: one busy cycle, then sweep_done with busy low, no result.
        launch(8'h00, 32'd100);
        @(negedge clk);
        check("t2_c1", 64'({busy, sweep_done, result_valid}), 64'(3'b100));
        @(negedge clk);
        check("t2_c2", 64'({busy, sweep_done, result_valid}), 64'(3'b010));
        @(negedge clk);
        check("t2_c3", 64'({busy, sweep_done, result_valid}), 64'(3'b000));

        // Timeout: integ 10 + margin 16 = 26 RUN cycles; a second start is dropped.
        done_at = 0; ring_count = 32'hDEAD_BEEF;
        launch(8'h01, 32'd10);
        @(negedge clk);
        bit_mask = 8'h02; integ = 32'd3; start = 1;
        @(posedge clk);
        #1 start = 0;
        wait_valid(300, cyc);
        check("t3_valid", 64'(result_valid), 64'(1));
        check("t3_res", 64'({result_bit, result_count, result_timeout}), 64'({4'd0, 32'hDEAD_BEEF, 1'b1}));
        check("t3_run", 64'(last_run), 64'(26));
        finish_sweep(pulses, vseen);
        check("t3_single", 64'({pulses[1:0], vseen, busy}), 64'(4'b0100));

        // done on the 26th cycle beats the watchdog.
        done_at = 26;
        launch(8'h01, 32'd10);
        wait_valid(300, cyc);
        check("t3b_res", 64'({result_bit, result_timeout}), 64'({4'd0, 1'b0}));
        check("t3b_run", 64'(last_run), 64'(26));
        finish_sweep(pulses, vseen);

        // Back-pressure: result holds for 50 cycles while ring input moves.
        result_ready = 0; done_at = 5; ring_count = 32'd77;
        launch(8'h01, 32'd20);
        wait_valid(300, cyc);
        ring_count = 32'd99;
        for (int i = 0; i < 50; i++) begin
            check("t4_hold", 64'({result_valid, counter_enable, stop_b, result_bit, result_timeout}),
                  64'({1'b1, 1'b0, 1'b0, 4'd0, 1'b0}));
            check("t4_count", 64'(result_count), 64'(77));
            @(negedge clk);
        end
        result_ready = 1;
        finish_sweep(pulses, vseen);
        check("t4_end", 64'({pulses[1:0], busy}), 64'(3'b010));

        // Reset during RUN returns every output to its reset value.
        done_at = 0;
        launch(8'h03, 32'd50);
        cyc = 0;
        while (!counter_enable && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("t5_in_run", 64'(counter_enable), 64'(1));
        repeat (3) @(negedge clk);
        reset_b = 0;
        @(posedge clk);
        #1;
        check("t5_ctl", 64'({adder_reset, stop_b, bypass_b, control_b, extra_inverter,
                             counter_enable, counter_load, busy, sweep_done, result_valid,
                             result_timeout}), 64'(11'b11110000000));
        check("t5_sel", 64'({a_ext_b, a_ring_b, s_out_b}), 64'(24'hFFFFFF));
        check("t5_data", 64'({integration_time, a_input, b_input, result_bit}), 64'(0));
        check("t5_count", 64'(result_count), 64'(0));
        @(negedge clk);
        reset_b = 1;
        repeat (3) @(negedge clk);
        check("t5_idle", 64'({busy, result_valid}), 64'(2'b00));

        // Top bit only; with the reference option a bypassed run comes first.
        done_at = 8; ring_count = 32'd555;
        launch(8'h80, 32'd8);
`ifdef ADDER_MEAS_BYPASS_REF_EN
        wait_valid(300, cyc);
        check("t6_ref", 64'({result_bit, result_count, run_byp, run_sel}), 64'({4'd8, 32'd555, 1'b0, 8'hFE}));
`endif
        wait_valid(300, cyc);
        check("t6_bit7", 64'({result_valid, result_bit, run_byp, run_sel}), 64'({1'b1, 4'd7, 1'b1, 8'h7F}));
        finish_sweep(pulses, vseen);
        check("t6_end", 64'({pulses[1:0], vseen, busy}), 64'(4'b0100));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/adder_measure_sequencer.md
Name: adder_measure_sequencer

Overview:
- Host-side initiator for the instrumented Kogge-Stone adder's logic-analyser control interface.
- Drives the ring/counter controls the adder consumes and reads back done and the ring-oscillator count.
- Sweeps a programmable set of sum bits, one timed measurement per bit, and returns results over a valid/ready stream.
- Replaces CPU bit-banging of la1/la2/la3 during characterisation runs.

Parameters:
- NUM_BITS, 8, adder width; sets mask/select widths.
- SETTLE_CYCLES, 4, cycles the adder is held in reset before the counter is loaded.
- TIMEOUT_MARGIN, 16, extra RUN cycles allowed beyond integration_time before declaring timeout.

Ports:
- wb_clk_i  in  1  system clock.
- reset_b  in  1  synchronous reset, active-low.
- start  in  1  begin sweep; ignored while busy.
- bit_mask  in  NUM_BITS  sum bits to measure; sampled on accepted start.
- integ_time_i  in  32  integration time; sampled on accepted start.
- a_val_i, b_val_i  in  NUM_BITS each  static adder operands; sampled on accepted start.
- busy  out  1  sweep in progress.
- sweep_done  out  1  one-cycle pulse at end of sweep.
- result_valid  out  1  result available.
- result_ready  in  1  consumer accepts result.
- result_bit  out  4  measured sum-bit index (8 = bypass reference).
- result_count  out  32  captured ring count.
- result_timeout  out  1  done was not seen in time.
- adder_reset, stop_b, bypass_b, control_b, extra_inverter  out  1 each  adder loop controls.
- a_input_ext_bit_b, a_input_ring_bit_b, s_output_bit_b  out  NUM_BITS each  inverted selects.
- counter_enable, counter_load  out  1 each  counter controls.
- integration_time  out  32  to adder.
- a_input, b_input  out  NUM_BITS each  to adder.
- done  in  1  from adder.
- ring_count_i  in  32  ring_osc_counter_out from adder.

Behaviour:
- Clocking and reset: one clock, wb_clk_i. reset_b is synchronous and active-low; it takes effect at the next edge, including mid-sweep, and aborts any in-flight result.
- Reset values:
  - adder_reset=1; stop_b=1; bypass_b=1; control_b=1; extra_inverter=0.
  - All select buses all-ones.
  - counter_enable=0, counter_load=0; integration_time=0; a_input=0, b_input=0.
  - busy=0; sweep_done=0; result_valid=0; result_bit/count/timeout=0.
- Sweep launch: start in IDLE latches the mask, time and operands; busy rises next cycle.
- Bit selection (index k):
  - Ring enters a-bit 0: a_input_ring_bit_b=~1, a_input_ext_bit_b=1.
  - Ring exits sum-bit k: s_output_bit_b=~(1<<k).
- Bit order: ascending index order over set mask bits.
- Empty mask: busy for exactly 1 cycle, then sweep_done pulses; no results.
- SETUP: adder_reset=1, stop_b=0, counter_enable=0, selects driven; lasts SETTLE_CYCLES cycles.
- LOAD: adder_reset=0, counter_load=1 for exactly 1 cycle.
- RUN:
  - stop_b=1, counter_enable=1.
  - Watchdog counts from 0, using a 33-bit compare against integ_time+TIMEOUT_MARGIN.
  - Exit on done=1 (timeout=0) or watchdog match (timeout=1); done wins if both occur in the same cycle.
- CAPTURE: stop_b=0, counter_enable=0, result_count<=ring_count_i; 1 cycle.
- RESULT:
  - result_valid=1; result fields stable until result_ready=1 is sampled.
  - Transfer occurs on valid&&ready.
  - Then go to SETUP for the next bit, or pulse sweep_done and return to IDLE; busy falls the same cycle sweep_done pulses.
- Latency: minimum start-to-first-result_valid = 1+SETTLE_CYCLES+1+run+1 cycles.
- start while busy: dropped, with no queuing.

Optional Feature:
- Macro: ADDER_MEAS_BYPASS_REF_EN.
- Defined: each non-empty sweep first runs one reference measurement with bypass_b=0 (adder bypassed), s_output_bit_b=~1, result_bit=8, then the masked bits.
- Undefined: bypass_b is held at 1 permanently and result_bit never equals 8.

Decomposition:
- Package adder_meas_pkg holds:
  - state enum: IDLE, SETUP, LOAD, RUN, CAPTURE, RESULT, FINISH;
  - RING_IN_BIT=0;
  - REF_INDEX=4'd8;
  - the result record typedef (bit, count, timeout).
- One sub-module, adder_meas_watchdog: 33-bit cycle counter with clear, enable and an expired flag.
- Next-set-bit search stays inline.

Test Plan:
- mask=8'h05, integ=100, done stub fires after 100 RUN cycles, count stub=1234:
  - results (bit0,1234,0) then (bit2,1234,0), ready held 1;
  - s_output_bit_b=8'hFE then 8'hFB;
  - sweep_done pulses once.
- mask=8'h00 -> sweep_done 1 cycle after busy rises; result_valid never asserts.
- integ=10, done tied 0 -> result_timeout=1 after exactly 26 RUN cycles; done asserted on cycle 26 -> timeout=0.
- result_ready held 0 for 50 cycles -> result_valid and fields stable; counter_enable=0 and stop_b=0 throughout.
- reset_b=0 during RUN -> next edge: all outputs at reset values, busy=0; second start pulse while busy ignored.
- ADDER_MEAS_BYPASS_REF_EN defined, mask=8'h80 -> first result_bit=8 with bypass_b=0 during RUN, then result_bit=7.
